bcd_score_converter: RTL
========================

BCD_SCORE_CONVERTER -- requirements
Module: bcd_score_converter

Interface
REQ-001 The block SHALL have one parameter: MAX_VALUE, default 20'd999999, the largest value shown on the six-digit display; inputs above it clamp to it.
REQ-002 The port list SHALL begin with clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 start, input, 1: request to convert bin_in; sampled each rising edge.
REQ-005 bin_in, input, 20: unsigned binary score; sampled only on the edge where start is accepted.
REQ-006 bcd_out, output, 24: six packed BCD digits; digit i occupies bits [4i+3:4i], digit 0 is least significant; each nibble feeds one hex display decoder.
REQ-007 blank, output, 6: bit i high means digit i is a leading zero and SHALL be blanked downstream.
REQ-008 busy, output, 1: high while a conversion is in progress.
REQ-009 done, output, 1: one-cycle pulse; bcd_out, blank and overflow are valid and newly updated in this cycle.
REQ-010 overflow, output, 1: the last accepted bin_in exceeded MAX_VALUE.

Function
REQ-011 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 IDLE: busy=0, done=0; start=1 on an edge SHALL capture min(bin_in, MAX_VALUE) into a 20-bit shift register, clear a 44-bit scratch (24 BCD + 20 binary) and a 5-bit counter, latch pending overflow, and go to SHIFT.
REQ-013 SHIFT: busy=1; on each edge, each of the six scratch BCD nibbles >=5 SHALL get +3, then scratch SHALL shift left one bit, taking in the next MSB of the captured value (double dabble); counter increments.
REQ-014 After exactly 20 SHIFT edges, the 20th edge SHALL write the final BCD result directly into bcd_out, update blank and overflow, and go to DONE.
REQ-015 DONE: busy=0, done=1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-016 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+20 and low otherwise.
REQ-017 start SHALL be ignored in SHIFT and DONE; no queuing. A start held high SHALL begin a new conversion on the first edge back in IDLE, i.e. every 22 cycles.
REQ-018 bcd_out, blank and overflow SHALL hold their previous values throughout SHIFT and DONE and change only on the final SHIFT edge; no intermediate values reach the display.
REQ-019 blank[0] SHALL always be 0. For i=1..5, blank[i]=1 iff digit i and every higher digit are zero.
REQ-020 overflow SHALL be 1 iff the accepted bin_in > MAX_VALUE; bcd_out then SHALL equal BCD(MAX_VALUE).
REQ-021 No BCD nibble of bcd_out SHALL ever exceed 9.

Reset
REQ-022 When reset=1 on an edge: state=IDLE, bcd_out=24'h000000, blank=6'b111110, busy=0, done=0, overflow=0, and counter and scratch cleared.
REQ-023 reset SHALL take priority over start and over any in-progress conversion; a conversion aborted by reset SHALL produce no done pulse and no bcd_out update.

Verification
REQ-024 Reset, then start with bin_in=0 -> done 20 cycles after the start edge, bcd_out=24'h000000, blank=6'b111110, overflow=0.
REQ-025 bin_in=123456 -> bcd_out=24'h123456, blank=6'b000000. bin_in=907 -> bcd_out=24'h000907, blank=6'b111000. bcd_out unchanged while busy=1.
REQ-026 bin_in=999999 -> bcd_out=24'h999999, overflow=0. bin_in=20'hFFFFF (1048575) -> bcd_out=24'h999999, overflow=1.
REQ-027 Pulse start again at cycles 3 and 20 of a conversion, with different bin_in -> ignored; the result matches the original bin_in and there is exactly one done pulse.
REQ-028 Assert reset at SHIFT cycle 10 after a prior result 24'h000042 -> bcd_out=24'h000000, no done pulse; a following start with bin_in=42 -> 24'h000042 after 20 cycles.
REQ-029 start held high for 100 cycles with bin_in=5 -> done pulses every 22 cycles, bcd_out=24'h000005 each time.

Source files
------------

// File: rtl/bcd_score_converter.sv
// bcd_score_converter: clamps a 20-bit binary score to MAX_VALUE and converts it
// to six packed BCD digits by serial double dabble (20 shift cycles), with
// leading-zero blanking and an overflow flag for the display.
module bcd_score_converter #(
   parameter logic [19:0] MAX_VALUE = 20'd999999
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [19:0] bin_in,
   output logic [23:0] bcd_out,
   output logic [5:0]  blank,
   output logic        busy,
   output logic        done,
   output logic        overflow
);

   localparam int unsigned BIN_W  = 20;
   localparam int unsigned BCD_W  = 24;
   localparam int unsigned DIGITS = 6;
   localparam int unsigned CNT_W  = 5;
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   // {bcd_scr, bin_sh} together form the 44-bit double-dabble scratch word
   logic [BCD_W-1:0]   bcd_scr;
   logic [BIN_W-1:0]   bin_sh;
   logic [CNT_W-1:0]   cnt;
   logic               ovf_pend;

   logic [BCD_W-1:0]   adj_bcd;
   logic [BCD_W-1:0]   next_bcd;
   logic [DIGITS-1:0]  next_blank;

   // Add-3 correction on every digit >= 5, then shift in the next binary MSB
   always_comb begin
      adj_bcd = bcd_scr;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd_scr[4*i +: 4] >= 4'd5)
            adj_bcd[4*i +: 4] = bcd_scr[4*i +: 4] + 4'd3;
      end
      next_bcd = {adj_bcd[BCD_W-2:0], bin_sh[BIN_W-1]};
   end

   // Leading-zero blanking of the result; the units digit is always shown
   always_comb begin
      next_blank = '0;
      next_blank[DIGITS-1] = (next_bcd[BCD_W-1 -: 4] == 4'd0);
      for (int i = int'(DIGITS) - 2; i >= 1; i--)
         next_blank[i] = next_blank[i+1] && (next_bcd[4*i +: 4] == 4'd0);
      next_blank[0] = 1'b0;
   end

   // Control FSM, scratch datapath and registered display outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         bcd_scr  <= '0;
         bin_sh   <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         bcd_out  <= '0;
         blank    <= 6'b111110;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  bin_sh   <= (bin_in > MAX_VALUE) ? MAX_VALUE : bin_in;
                  bcd_scr  <= '0;
                  cnt      <= '0;
                  ovf_pend <= (bin_in > MAX_VALUE);
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_scr <= next_bcd;
               bin_sh  <= {bin_sh[BIN_W-2:0], 1'b0};
               cnt     <= cnt + CNT_W'(1);
               if (cnt == LAST_SHIFT) begin
                  bcd_out  <= next_bcd;
                  blank    <= next_blank;
                  overflow <= ovf_pend;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
